// File: rtl/hotp_pkg.sv
// Shared types and constants for the multi-slot HOTP stream front-end.
// Imported by the key store and the top-level sequencer.
package hotp_pkg;

   localparam int CORE_BITS = 512;
   localparam int CNT_W     = 13;

   typedef enum logic [2:0] {
      IDLE,
      K1,
      MSG,
      K2,
      CAP
   } phase_t;

   function automatic int slot_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hotp_key_store.sv
// Per-slot HMAC key buffers with bit-serial, left-aligned loading and length tracking.
// One write port (slot, bit, clear) and one read port (slot, index).
module hotp_key_store
   import hotp_pkg::*;
#(
   parameter  int NUM_SLOTS = 2,
   parameter  int KEY_MAX   = 160,
   localparam int SLOT_W    = slot_width(NUM_SLOTS),
   localparam int LEN_W     = $clog2(KEY_MAX + 1),
   localparam int IDX_W     = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic              i_wr_clr,
   input  logic [SLOT_W-1:0] i_wr_slot,
   input  logic              i_wr_bit,
   input  logic [SLOT_W-1:0] i_rd_slot,
   input  logic [IDX_W-1:0]  i_rd_idx,
   input  logic [SLOT_W-1:0] i_chk_slot,
   output logic              o_rd_bit,
   output logic [LEN_W-1:0]  o_wr_len,
   output logic [LEN_W-1:0]  o_chk_len
);

   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(KEY_MAX);
   localparam logic [LEN_W-1:0] LEN_TOP  = LEN_W'(KEY_MAX - 1);

   logic [KEY_MAX-1:0] r_key_buf [NUM_SLOTS];
   logic [LEN_W-1:0]   r_len     [NUM_SLOTS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            r_len[s] <= '0;
         end
      end else if (i_wr_en) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (i_wr_slot == SLOT_W'(s)) begin
               if (i_wr_clr) begin
                  r_len[s] <= LEN_W'(1);
               end else if (r_len[s] != LEN_FULL) begin
                  r_len[s] <= r_len[s] + LEN_W'(1);
               end
            end
         end
      end
   end

   // NOTE: the key buffers carry no reset; each load clears its slot first and a zero-length slot is never run.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (i_wr_slot == SLOT_W'(s)) begin
               if (i_wr_clr) begin
                  r_key_buf[s]              <= '0;
                  r_key_buf[s][KEY_MAX-1]   <= i_wr_bit;
               end else if (r_len[s] != LEN_FULL) begin
                  r_key_buf[s][IDX_W'(LEN_TOP - r_len[s])] <= i_wr_bit;
               end
            end
         end
      end
   end

   // NOTE: every output gets a default before the loop so no latch is inferred for unmatched slots.
   always_comb begin
      o_rd_bit  = 1'b0;
      o_wr_len  = '0;
      o_chk_len = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (i_rd_slot == SLOT_W'(s)) begin
            o_rd_bit = r_key_buf[s][i_rd_idx];
         end
         if (i_wr_slot == SLOT_W'(s)) begin
            o_wr_len = r_len[s];
         end
         if (i_chk_slot == SLOT_W'(s)) begin
            o_chk_len = r_len[s];
         end
      end
   end

endmodule

// File: rtl/hotp_stream_multi.sv
// Multi-slot HOTP stream front-end: loads keys and message serially, sequences the
// bit-serial HMAC-SHA1/truncation core through K1/MSG/K2, then captures BCD digits.
module hotp_stream_multi
   import hotp_pkg::*;
#(
   parameter  int NUM_SLOTS    = 2,
   parameter  int KEY_MAX      = 160,
   parameter  int MSG_BITS     = 64,
   parameter  int DIGITS       = 6,
   parameter  int BLOCK_CYCLES = 2720,
   parameter  int FINAL_CYCLES = 6017,
   localparam int SLOT_W       = slot_width(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data,
   input  logic              key_en,
   input  logic              msg_en,
   input  logic [SLOT_W-1:0] slot,
   input  logic              start,
   input  logic              abort,
   input  logic [2:0]        sel,
   input  logic              hotp_out,
   output logic              busy,
   output logic              ready,
   output logic              error,
   output logic [3:0]        bcd,
   output logic              hotp_rst_n,
   output logic              hotp_in
);

   localparam int LEN_W  = $clog2(KEY_MAX + 1);
   localparam int IDX_W  = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
   localparam int MCNT_W = $clog2(MSG_BITS + 1);
   localparam int MIDX_W = $clog2(MSG_BITS);
   localparam int DIG_W  = 4 * DIGITS;

   localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(KEY_MAX);
   localparam logic [MCNT_W-1:0] MCNT_FULL = MCNT_W'(MSG_BITS);
   localparam logic [CNT_W-1:0]  C_KEY     = CNT_W'(KEY_MAX);
   localparam logic [CNT_W-1:0]  C_KEY_TOP = CNT_W'(KEY_MAX - 1);
   localparam logic [CNT_W-1:0]  C_MSG     = CNT_W'(MSG_BITS);
   localparam logic [CNT_W-1:0]  C_MSG_TOP = CNT_W'(MSG_BITS - 1);
   localparam logic [CNT_W-1:0]  C_BLK_END = CNT_W'(BLOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  C_FIN_END = CNT_W'(FINAL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  C_CAP     = CNT_W'(DIG_W);

   phase_t              r_state;
   phase_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [SLOT_W-1:0]   r_run_slot;
   logic [SLOT_W-1:0]   r_load_slot;
   logic                r_key_en_d;
   logic                r_msg_en_d;
   logic [MSG_BITS-1:0] r_msg;
   logic [MCNT_W-1:0]   r_msg_cnt;
   logic [DIG_W-1:0]    r_digest;
   logic                r_ready;
   logic                r_error;
   logic [3:0]          r_bcd;

   logic                w_idle;
   logic                w_key_wr;
   logic                w_key_clr;
   logic [SLOT_W-1:0]   w_wr_slot;
   logic [LEN_W-1:0]    w_wr_len;
   logic [LEN_W-1:0]    w_chk_len;
   logic                w_key_ovf;
   logic                w_msg_wr;
   logic                w_msg_clr;
   logic                w_msg_ovf;
   logic                w_busy_load;
   logic                w_start_req;
   logic                w_start_ok;
   logic                w_start_bad;
   logic                w_cap_sample;
   logic                w_cap_done;
   logic [IDX_W-1:0]    w_key_idx;
   logic [MIDX_W-1:0]   w_msg_idx;
   logic                w_key_bit;
   logic [3:0]          w_digit;

   hotp_key_store #(
      .NUM_SLOTS (NUM_SLOTS),
      .KEY_MAX   (KEY_MAX)
   ) u_key_store (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_key_wr),
      .i_wr_clr   (w_key_clr),
      .i_wr_slot  (w_wr_slot),
      .i_wr_bit   (data),
      .i_rd_slot  (r_run_slot),
      .i_rd_idx   (w_key_idx),
      .i_chk_slot (slot),
      .o_rd_bit   (w_key_bit),
      .o_wr_len   (w_wr_len),
      .o_chk_len  (w_chk_len)
   );

   assign w_idle      = (r_state == IDLE);
   assign w_key_wr    = w_idle & key_en;
   assign w_key_clr   = ~r_key_en_d;
   assign w_wr_slot   = w_key_clr ? slot : r_load_slot;
   assign w_key_ovf   = w_key_wr & ~w_key_clr & (w_wr_len == LEN_FULL);
   assign w_msg_wr    = w_idle & msg_en;
   assign w_msg_clr   = ~r_msg_en_d;
   assign w_msg_ovf   = w_msg_wr & ~w_msg_clr & (r_msg_cnt == MCNT_FULL);
   assign w_busy_load = ~w_idle & (key_en | msg_en);

   // Abort has priority over start; a start alongside a load is not a run request.
   assign w_start_req = w_idle & start & ~abort & ~key_en & ~msg_en;
   assign w_start_ok  = w_start_req & (w_chk_len != '0);
   assign w_start_bad = w_start_req & (w_chk_len == '0);

   assign w_cap_sample = (r_state == CAP) & (r_cnt < C_CAP);
   assign w_cap_done   = (r_state == CAP) & (r_cnt == C_CAP) & ~abort;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_start_ok)          w_state_nxt = K1;
         K1:      if (r_cnt == C_BLK_END)  w_state_nxt = MSG;
         MSG:     if (r_cnt == C_BLK_END)  w_state_nxt = K2;
         K2:      if (r_cnt == C_FIN_END)  w_state_nxt = CAP;
         CAP:     if (r_cnt == C_CAP)      w_state_nxt = IDLE;
         default:                          w_state_nxt = IDLE;
      endcase
      if (abort && !w_idle) begin
         w_state_nxt = IDLE;
      end
   end

   // The message is read in place rather than shifted so an aborted run leaves it intact.
   assign w_key_idx = IDX_W'(C_KEY_TOP - r_cnt);
   assign w_msg_idx = MIDX_W'(C_MSG_TOP - r_cnt);

   always_comb begin
      hotp_in = 1'b0;
      unique case (r_state)
         K1, K2:  hotp_in = (r_cnt < C_KEY) & w_key_bit;
         MSG:     hotp_in = (r_cnt < C_MSG) & r_msg[w_msg_idx];
         default: hotp_in = 1'b0;
      endcase
   end

   always_comb begin
      w_digit = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (sel == 3'(i)) begin
            w_digit = r_digest[4*i +: 4];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state || w_idle) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run_slot  <= '0;
         r_load_slot <= '0;
         r_key_en_d  <= 1'b0;
         r_msg_en_d  <= 1'b0;
         r_msg       <= '0;
         r_msg_cnt   <= '0;
         r_digest    <= '0;
         r_ready     <= 1'b0;
         r_error     <= 1'b0;
         r_bcd       <= '0;
      end else begin
         r_key_en_d <= key_en;
         r_msg_en_d <= msg_en;

         if (w_key_wr && w_key_clr) begin
            r_load_slot <= slot;
         end

         if (w_msg_wr) begin
            if (w_msg_clr) begin
               r_msg     <= {{(MSG_BITS-1){1'b0}}, data};
               r_msg_cnt <= MCNT_W'(1);
            end else begin
               r_msg <= {r_msg[MSG_BITS-2:0], data};
               if (!w_msg_ovf) begin
                  r_msg_cnt <= r_msg_cnt + MCNT_W'(1);
               end
            end
         end

         if (w_start_ok) begin
            r_run_slot <= slot;
            r_digest   <= '0;
         end else if (w_cap_sample) begin
            r_digest <= {hotp_out, r_digest[DIG_W-1:1]};
         end

         if (w_start_ok || w_key_wr || w_msg_wr) begin
            r_ready <= 1'b0;
         end else if (w_cap_done) begin
            r_ready <= 1'b1;
         end

         if (w_start_ok) begin
            r_error <= 1'b0;
         end else if (w_key_ovf || w_msg_ovf || w_busy_load || w_start_bad) begin
            r_error <= 1'b1;
         end

         r_bcd <= w_digit;
      end
   end

   assign busy       = ~w_idle;
   assign hotp_rst_n = ~w_idle;
   assign ready      = r_ready;
   assign error      = r_error;
   assign bcd        = r_bcd;

endmodule
